// File: rtl/axi_sram_slave.sv
// AXI4 burst slave in front of a single-port synchronous word SRAM.
// Serves one INCR/FIXED read or write burst at a time.
module axi_sram_slave #(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int SRAM_AW = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     S_AWID,
  input  logic [ADDR_W-1:0]   S_AWAddr,
  input  logic [LEN_W-1:0]    S_AWLen,
  input  logic [2:0]          S_AWSize,
  input  logic [1:0]          S_AWBurst,
  input  logic                S_AWValid,
  output logic                S_AWReady,
  input  logic [DATA_W-1:0]   S_WData,
  input  logic [DATA_W/8-1:0] S_WStrb,
  input  logic                S_WLast,
  input  logic                S_WValid,
  output logic                S_WReady,
  output logic [ID_W-1:0]     S_BID,
  output logic [1:0]          S_BResp,
  output logic                S_BValid,
  input  logic                S_BReady,
  input  logic [ID_W-1:0]     S_ARID,
  input  logic [ADDR_W-1:0]   S_ARAddr,
  input  logic [LEN_W-1:0]    S_ARLen,
  input  logic [2:0]          S_ARSize,
  input  logic [1:0]          S_ARBurst,
  input  logic                S_ARValid,
  output logic                S_ARReady,
  output logic [ID_W-1:0]     S_RID,
  output logic [DATA_W-1:0]   S_RData,
  output logic [1:0]          S_RResp,
  output logic                S_RLast,
  output logic                S_RValid,
  input  logic                S_RReady,
  output logic                sram_ceb,
  output logic [DATA_W/8-1:0] sram_web,
  output logic [SRAM_AW-1:0]  sram_a,
  output logic [DATA_W-1:0]   sram_di,
  input  logic [DATA_W-1:0]   sram_do
);

  localparam int CW = LEN_W + 1;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RDATA,
    WDATA,
    WRESP
  } state_t;

  state_t state, state_nx;

  logic [ID_W-1:0]    id_q;
  logic [LEN_W-1:0]   len_q;
  logic [1:0]         burst_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_AW-1:0] addr_nx;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_inc;
  logic [CW-1:0]      beats_req;
  logic [1:0]         bresp_q;

  logic aw_hs;
  logic ar_hs;
  logic w_hs;
  logic r_hs;

  // AxSize and out-of-range address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{S_AWSize, S_ARSize,
                         S_AWAddr[ADDR_W-1:SRAM_AW+2],
                         S_ARAddr[ADDR_W-1:SRAM_AW+2],
                         S_AWAddr[1:0], S_ARAddr[1:0]};

  assign S_AWReady = (state == IDLE);
  assign S_ARReady = (state == IDLE) & ~S_AWValid;
  assign S_WReady  = (state == WDATA);
  assign S_BValid  = (state == WRESP);
  assign S_RValid  = (state == RDATA);

  assign S_BID   = id_q;
  assign S_BResp = bresp_q;
  assign S_RID   = id_q;
  assign S_RResp = RESP_OKAY;
  assign S_RData = sram_do;
  assign S_RLast = (cnt_q == {1'b0, len_q}) & S_RValid;

  assign aw_hs = S_AWValid & S_AWReady;
  assign ar_hs = S_ARValid & S_ARReady;
  assign w_hs  = S_WValid & S_WReady;
  assign r_hs  = S_RValid & S_RReady;

  assign addr_nx = (burst_q == BURST_FIXED) ? addr_q
                                            : addr_q + SRAM_AW'(1);

  // saturate so a runaway write burst can never alias a legal length
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  assign beats_req = {1'b0, len_q} + CW'(1);

  always_comb begin
    state_nx = state;
    sram_ceb = 1'b1;
    sram_web = '1;
    sram_a   = addr_q;
    sram_di  = S_WData;
    unique case (state)
      IDLE: begin
        if (aw_hs) begin
          state_nx = WDATA;
        end else if (ar_hs) begin
          state_nx = RDATA;
          sram_ceb = 1'b0;
          sram_a   = S_ARAddr[SRAM_AW+1:2];
        end
      end
      WDATA: begin
        if (w_hs) begin
          sram_ceb = 1'b0;
          sram_web = ~S_WStrb;
          if (S_WLast) state_nx = WRESP;
        end
      end
      WRESP: begin
        if (S_BReady) state_nx = IDLE;
      end
      RDATA: begin
        sram_ceb = 1'b0;
        if (r_hs) begin
          if (S_RLast) state_nx = IDLE;
          else         sram_a   = addr_nx;
        end
      end
    endcase
    if (rst) begin
      sram_ceb = 1'b1;
      sram_web = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      state <= state_nx;
      if (aw_hs) begin
        id_q    <= S_AWID;
        len_q   <= S_AWLen;
        burst_q <= S_AWBurst;
        addr_q  <= S_AWAddr[SRAM_AW+1:2];
        cnt_q   <= '0;
      end else if (ar_hs) begin
        id_q    <= S_ARID;
        len_q   <= S_ARLen;
        burst_q <= S_ARBurst;
        addr_q  <= S_ARAddr[SRAM_AW+1:2];
        cnt_q   <= '0;
      end
      if (w_hs) begin
        addr_q <= addr_nx;
        cnt_q  <= cnt_inc;
        if (S_WLast) begin
          bresp_q <= (cnt_inc == beats_req) ? RESP_OKAY
                                            : RESP_SLVERR;
        end
      end
      if (r_hs & ~S_RLast) begin
        addr_q <= addr_nx;
        cnt_q  <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave against a transaction-level
// memory model, with a behavioural SRAM behind the DUT.
`timescale 1ns/1ps
module tb_axi_sram_slave;

  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  S_AWID;
  logic [31:0] S_AWAddr;
  logic [3:0]  S_AWLen;
  logic [2:0]  S_AWSize;
  logic [1:0]  S_AWBurst;
  logic        S_AWValid;
  logic        S_AWReady;
  logic [31:0] S_WData;
  logic [3:0]  S_WStrb;
  logic        S_WLast;
  logic        S_WValid;
  logic        S_WReady;
  logic [7:0]  S_BID;
  logic [1:0]  S_BResp;
  logic        S_BValid;
  logic        S_BReady;
  logic [7:0]  S_ARID;
  logic [31:0] S_ARAddr;
  logic [3:0]  S_ARLen;
  logic [2:0]  S_ARSize;
  logic [1:0]  S_ARBurst;
  logic        S_ARValid;
  logic        S_ARReady;
  logic [7:0]  S_RID;
  logic [31:0] S_RData;
  logic [1:0]  S_RResp;
  logic        S_RLast;
  logic        S_RValid;
  logic        S_RReady;
  logic        sram_ceb;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_di;
  logic [31:0] sram_do = '0;

  axi_sram_slave dut (
    .clk(clk), .rst(rst),
    .S_AWID(S_AWID), .S_AWAddr(S_AWAddr), .S_AWLen(S_AWLen),
    .S_AWSize(S_AWSize), .S_AWBurst(S_AWBurst),
    .S_AWValid(S_AWValid), .S_AWReady(S_AWReady),
    .S_WData(S_WData), .S_WStrb(S_WStrb), .S_WLast(S_WLast),
    .S_WValid(S_WValid), .S_WReady(S_WReady),
    .S_BID(S_BID), .S_BResp(S_BResp), .S_BValid(S_BValid),
    .S_BReady(S_BReady),
    .S_ARID(S_ARID), .S_ARAddr(S_ARAddr), .S_ARLen(S_ARLen),
    .S_ARSize(S_ARSize), .S_ARBurst(S_ARBurst),
    .S_ARValid(S_ARValid), .S_ARReady(S_ARReady),
    .S_RID(S_RID), .S_RData(S_RData), .S_RResp(S_RResp),
    .S_RLast(S_RLast), .S_RValid(S_RValid), .S_RReady(S_RReady),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic        last;
  } rexp_t;

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } bexp_t;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wdat [32];
  logic [3:0]  wstb [32];
  rexp_t rq[$];
  bexp_t bq[$];

  int total = 0;
  int bad   = 0;
  int rbeats = 0;
  int whs    = 0;
  int rmode  = 2;
  int bmode  = 1;
  bit abort  = 1'b0;
  logic [31:0] last_rdata = '0;
  logic [7:0]  last_rid   = '0;
  logic [1:0]  last_bresp = '0;
  logic [7:0]  last_bid   = '0;
  logic [13:0] last_wa    = '0;
  logic [3:0]  last_web   = '1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // behavioural SRAM: one-cycle read latency, byte write enables
  initial begin
    logic [31:0] m;
    forever begin
      @(posedge clk);
      if (!sram_ceb) begin
        if (sram_web == 4'hF) begin
          sram_do <= mem[sram_a];
        end else begin
          m = mem[sram_a];
          for (int b = 0; b < 4; b++)
            if (!sram_web[b]) m[8*b +: 8] = sram_di[8*b +: 8];
          mem[sram_a] <= m;
        end
      end
    end
  end

  // response-side ready generation
  initial begin
    int cyc = 0;
    S_RReady = 1'b0;
    S_BReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rmode)
        0: S_RReady = 1'($urandom_range(0, 1));
        1: S_RReady = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: S_RReady = 1'b1;
      endcase
      S_BReady = (bmode != 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // compare process
  initial begin
    bit ar_seen = 1'b0;
    rexp_t re;
    bexp_t be;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_seen = 1'b0;
      end else begin
        if (ar_seen) chk("rvalid_latency", S_RValid, 1);
        ar_seen = S_ARValid & S_ARReady;
        chk("ar_vs_aw", S_ARReady & S_AWValid, 0);
        if (S_RValid) begin
          if (rq.size() == 0) begin
            chk("r_spurious", S_RValid, 0);
          end else begin
            re = rq[0];
            chk("rdata", S_RData, re.data);
            chk("rid", S_RID, re.id);
            chk("rlast", S_RLast, re.last);
            chk("rresp", S_RResp, 0);
            if (S_RReady) begin
              void'(rq.pop_front());
              rbeats++;
              last_rdata = S_RData;
              last_rid   = S_RID;
            end
          end
        end
        if (S_BValid) begin
          if (bq.size() == 0) begin
            chk("b_spurious", S_BValid, 0);
          end else begin
            be = bq[0];
            chk("bid", S_BID, be.id);
            chk("bresp", S_BResp, be.resp);
            if (S_BReady) begin
              void'(bq.pop_front());
              last_bresp = S_BResp;
              last_bid   = S_BID;
            end
          end
        end
        if (S_WValid && S_WReady) whs++;
        if (!sram_ceb && sram_web != 4'hF) begin
          last_wa  = sram_a;
          last_web = sram_web;
        end
      end
    end
  end

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      wdat[i] = $urandom;
      wstb[i] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic wr_prep(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst,
                         input int n);
    int w;
    bexp_t be;
    w = int'(addr[15:2]);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++)
        if (wstb[i][b]) ref_mem[w][8*b +: 8] = wdat[i][8*b +: 8];
      if (burst != 2'b00) w = (w + 1) % DEPTH;
    end
    be.id   = id;
    be.resp = (n == int'(len) + 1) ? 2'b00 : 2'b10;
    bq.push_back(be);
  endtask

  task automatic rd_prep(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
    int w;
    rexp_t re;
    w = int'(addr[15:2]);
    for (int i = 0; i <= int'(len); i++) begin
      re.id   = id;
      re.data = ref_mem[w];
      re.last = (i == int'(len));
      rq.push_back(re);
      if (burst != 2'b00) w = (w + 1) % DEPTH;
    end
  endtask

  task automatic wr_run(input logic [7:0] id, input logic [31:0] addr,
                        input logic [3:0] len, input logic [1:0] burst,
                        input int n, input bit gaps);
    int to;
    S_AWID = id; S_AWAddr = addr; S_AWLen = len;
    S_AWBurst = burst; S_AWSize = 3'd2; S_AWValid = 1'b1;
    to = 0;
    do begin @(negedge clk); to++; end
    while (!S_AWReady && to < 300 && !abort);
    if (!abort) chk("aw_ready", S_AWReady, 1);
    @(posedge clk); #1;
    S_AWValid = 1'b0;
    for (int i = 0; i < n && !abort; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      S_WData = wdat[i]; S_WStrb = wstb[i];
      S_WLast = (i == n - 1); S_WValid = 1'b1;
      to = 0;
      do begin @(negedge clk); to++; end
      while (!S_WReady && to < 300 && !abort);
      if (!abort) chk("w_ready", S_WReady, 1);
      @(posedge clk); #1;
      S_WValid = 1'b0; S_WLast = 1'b0;
    end
  endtask

  task automatic rd_run(input logic [7:0] id, input logic [31:0] addr,
                        input logic [3:0] len, input logic [1:0] burst);
    int to;
    S_ARID = id; S_ARAddr = addr; S_ARLen = len;
    S_ARBurst = burst; S_ARSize = 3'd2; S_ARValid = 1'b1;
    to = 0;
    do begin @(negedge clk); to++; end
    while (!S_ARReady && to < 300);
    chk("ar_ready", S_ARReady, 1);
    @(posedge clk); #1;
    S_ARValid = 1'b0;
  endtask

  task automatic drain();
    int to = 0;
    while ((rq.size() != 0 || bq.size() != 0) && to < 400) begin
      @(posedge clk); #1; to++;
    end
    chk("drain", 32'(rq.size() + bq.size()), 0);
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst,
                          input int n, input bit gaps);
    wr_prep(id, addr, len, burst, n);
    wr_run(id, addr, len, burst, n, gaps);
    drain();
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
    rd_prep(id, addr, len, burst);
    rd_run(id, addr, len, burst);
    drain();
  endtask

  task automatic pulse_reset();
    rst = 1'b1; abort = 1'b1;
    rq.delete(); bq.delete();
    @(negedge clk);
    chk("ceb_in_reset", sram_ceb, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", S_RValid, 0);
    chk("post_rst_bvalid", S_BValid, 0);
    chk("post_rst_ceb", sram_ceb, 1);
    chk("post_rst_awready", S_AWReady, 1);
    repeat (5) begin @(posedge clk); #1; end
    abort = 1'b0;
    S_AWValid = 1'b0; S_WValid = 1'b0; S_WLast = 1'b0; S_ARValid = 1'b0;
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, to, n;
    logic [31:0] a;
    logic [3:0] l;
    logic [1:0] bt;
    S_AWID = '0; S_AWAddr = '0; S_AWLen = '0; S_AWSize = '0;
    S_AWBurst = '0; S_AWValid = 1'b0;
    S_WData = '0; S_WStrb = '0; S_WLast = 1'b0; S_WValid = 1'b0;
    S_ARID = '0; S_ARAddr = '0; S_ARLen = '0; S_ARSize = '0;
    S_ARBurst = '0; S_ARValid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'hA5A5_0000 | 32'(i);
      ref_mem[i] = 32'hA5A5_0000 | 32'(i);
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_awready", S_AWReady, 1);
    chk("rst_arready", S_ARReady, 1);
    chk("rst_wready", S_WReady, 0);
    chk("rst_bvalid", S_BValid, 0);
    chk("rst_rvalid", S_RValid, 0);
    chk("rst_bresp", S_BResp, 0);
    chk("rst_bid", S_BID, 0);
    chk("rst_rid", S_RID, 0);
    chk("rst_ceb", sram_ceb, 1);
    chk("rst_web", sram_web, 4'hF);
    @(posedge clk); #1;

    // 16-beat read under a 1,0,0,1 RReady pattern
    rmode = 1;
    r0 = rbeats;
    do_read(8'h07, 32'h0, 4'd15, 2'b01);
    chk("t2_beats", 32'(rbeats - r0), 16);
    chk("t2_last_word", last_rdata, 32'hA5A5_000F);
    rmode = 2;

    // single partial-strobe write and read-back
    wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'b0011;
    do_write(8'h5A, 32'h100, 4'd0, 2'b01, 1, 1'b0);
    chk("t1_web", last_web, 4'b1100);
    chk("t1_addr", last_wa, 14'h40);
    chk("t1_bresp", last_bresp, 2'b00);
    chk("t1_bid", last_bid, 8'h5A);
    do_read(8'h3C, 32'h100, 4'd0, 2'b01);
    chk("t1_readback", last_rdata, 32'hA5A5_BEEF);
    chk("t1_rid", last_rid, 8'h3C);

    // AW and AR presented together: write must go first
    bmode = 0;
    fill_rand(2);
    wstb[0] = 4'hF; wstb[1] = 4'hF;
    wr_prep(8'h11, 32'h200, 4'd1, 2'b01, 2);
    rd_prep(8'h22, 32'h200, 4'd1, 2'b01);
    fork
      wr_run(8'h11, 32'h200, 4'd1, 2'b01, 2, 1'b0);
      rd_run(8'h22, 32'h200, 4'd1, 2'b01);
      begin
        @(negedge clk);
        chk("both_arready", S_ARReady, 0);
        chk("both_awready", S_AWReady, 1);
      end
    join
    drain();
    chk("both_rdata", last_rdata, ref_mem[129]);
    bmode = 1;

    // short and long bursts relative to AWLen
    fill_rand(2);
    w0 = whs;
    do_write(8'h31, 32'h400, 4'd3, 2'b01, 2, 1'b0);
    chk("t4a_beats", 32'(whs - w0), 2);
    chk("t4a_bresp", last_bresp, 2'b10);
    fill_rand(3);
    w0 = whs;
    do_write(8'h32, 32'h440, 4'd1, 2'b01, 3, 1'b1);
    chk("t4b_beats", 32'(whs - w0), 3);
    chk("t4b_bresp", last_bresp, 2'b10);
    do_read(8'h33, 32'h400, 4'd7, 2'b01);
    do_read(8'h34, 32'h440, 4'd3, 2'b01);

    // FIXED burst keeps hitting the same word
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'(i + 1); wstb[i] = 4'hF;
    end
    do_write(8'h41, 32'h20, 4'd3, 2'b00, 4, 1'b0);
    chk("t5_addr", last_wa, 14'h8);
    chk("t5_bresp", last_bresp, 2'b00);
    do_read(8'h42, 32'h20, 4'd0, 2'b01);
    chk("t5_readback", last_rdata, 32'h4);
    do_read(8'h43, 32'h20, 4'd3, 2'b00);

    // INCR wrap past the top of the SRAM, upper address bits ignored
    fill_rand(4);
    do_write(8'h51, 32'hFFFF_FFF8, 4'd3, 2'b01, 4, 1'b1);
    do_read(8'h52, 32'h0003_FFF8, 4'd3, 2'b01);

    // reset mid-read
    r0 = rbeats;
    rd_prep(8'h61, 32'h800, 4'd15, 2'b01);
    rd_run(8'h61, 32'h800, 4'd15, 2'b01);
    to = 0;
    while (rbeats < r0 + 5 && to < 100) begin
      @(posedge clk); #1; to++;
    end
    chk("rst_read_progress", 32'(rbeats - r0), 5);
    pulse_reset();

    // reset mid-write, then a clean overwrite of the same words
    fill_rand(8);
    for (int i = 0; i < 8; i++) wstb[i] = 4'hF;
    wr_prep(8'h71, 32'hC00, 4'd7, 2'b01, 8);
    w0 = whs;
    fork
      wr_run(8'h71, 32'hC00, 4'd7, 2'b01, 8, 1'b0);
    join_none
    to = 0;
    while (whs < w0 + 2 && to < 100) begin
      @(posedge clk); #1; to++;
    end
    chk("rst_write_progress", 32'(whs - w0), 2);
    pulse_reset();
    fill_rand(8);
    for (int i = 0; i < 8; i++) wstb[i] = 4'hF;
    do_write(8'h72, 32'hC00, 4'd7, 2'b01, 8, 1'b0);
    chk("post_rst_bresp", last_bresp, 2'b00);
    do_read(8'h73, 32'hC00, 4'd7, 2'b01);

    // randomized traffic
    rmode = 0;
    bmode = 0;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 255)) << 2;
      l  = 4'($urandom_range(0, 15));
      bt = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20))
                                        : int'(l) + 1;
        fill_rand(n);
        do_write(8'($urandom), a, l, bt, n, 1'b1);
      end else begin
        do_read(8'($urandom), a, l, bt);
      end
    end

    begin
      int mism = 0;
      for (int i = 0; i < DEPTH; i++)
        if (mem[i] !== ref_mem[i]) mism++;
      chk("mem_image", 32'(mism), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
